// File: rtl/mem_arbiter_if.sv
// Bundle of core-side request/response channels and the single memory port
// shared by the arbiter. The arbiter takes the slave view; the core and the
// memory model together take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction read channel
  logic                  INST_RDEN;
  logic [ADDR_W-1:0]     INST_RIADDR;
  logic [ADDR_W-1:0]     INST_ROADDR;
  logic                  INST_RVALID;
  logic [DATA_W-1:0]     INST_RDATA;
  // Data read channel
  logic                  DATA_RDEN;
  logic [ADDR_W-1:0]     DATA_RIADDR;
  logic [ADDR_W-1:0]     DATA_ROADDR;
  logic                  DATA_RVALID;
  logic [DATA_W-1:0]     DATA_RDATA;
  // Data write channel
  logic                  DATA_WREN;
  logic [DATA_W/8-1:0]   DATA_WSTRB;
  logic [ADDR_W-1:0]     DATA_WADDR;
  logic [DATA_W-1:0]     DATA_WDATA;
  // Core stall
  logic                  ARB_WAIT;
  // Shared memory port
  logic                  MEM_RDEN;
  logic [ADDR_W-1:0]     MEM_RADDR;
  logic                  MEM_RVALID;
  logic [DATA_W-1:0]     MEM_RDATA;
  logic                  MEM_WREN;
  logic [DATA_W/8-1:0]   MEM_WSTRB;
  logic [ADDR_W-1:0]     MEM_WADDR;
  logic [DATA_W-1:0]     MEM_WDATA;
  logic                  MEM_WAIT;

  modport slave (
    input  INST_RDEN, INST_RIADDR,
    output INST_ROADDR, INST_RVALID, INST_RDATA,
    input  DATA_RDEN, DATA_RIADDR,
    output DATA_ROADDR, DATA_RVALID, DATA_RDATA,
    input  DATA_WREN, DATA_WSTRB, DATA_WADDR, DATA_WDATA,
    output ARB_WAIT,
    output MEM_RDEN, MEM_RADDR,
    input  MEM_RVALID, MEM_RDATA,
    output MEM_WREN, MEM_WSTRB, MEM_WADDR, MEM_WDATA,
    input  MEM_WAIT
  );

  modport master (
    output INST_RDEN, INST_RIADDR,
    input  INST_ROADDR, INST_RVALID, INST_RDATA,
    output DATA_RDEN, DATA_RIADDR,
    input  DATA_ROADDR, DATA_RVALID, DATA_RDATA,
    output DATA_WREN, DATA_WSTRB, DATA_WADDR, DATA_WDATA,
    input  ARB_WAIT,
    input  MEM_RDEN, MEM_RADDR,
    output MEM_RVALID, MEM_RDATA,
    input  MEM_WREN, MEM_WSTRB, MEM_WADDR, MEM_WDATA,
    output MEM_WAIT
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction-read, data-read and data-write
// channels. Requests are latched into per-channel slots while the core is not
// stalled, then served one at a time with priority write > data read > inst
// read. Only one memory transaction is ever in flight.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_W,
    ST_ISSUE_DR,
    ST_ISSUE_IR,
    ST_WAIT_DR,
    ST_WAIT_IR
  } state_e;

  state_e              state_q, state_d;
  // Pending slots
  logic                ir_vld_q, ir_vld_d;
  logic [ADDR_W-1:0]   ir_addr_q, ir_addr_d;
  logic                dr_vld_q, dr_vld_d;
  logic [ADDR_W-1:0]   dr_addr_q, dr_addr_d;
  logic                w_vld_q, w_vld_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]   w_strb_q, w_strb_d;
  // Registered response channels
  logic                inst_rvalid_q, inst_rvalid_d;
  logic [ADDR_W-1:0]   inst_roaddr_q, inst_roaddr_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic                data_rvalid_q, data_rvalid_d;
  logic [ADDR_W-1:0]   data_roaddr_q, data_roaddr_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

  logic                arb_wait;
  logic                capture;

  // Stall while anything is pending or in flight; MEM_WAIT also blocks capture
  // so a request is never latched on a cycle the memory is refusing issues.
  assign arb_wait = ir_vld_q | dr_vld_q | w_vld_q | (state_q != ST_IDLE) | bus.MEM_WAIT;
  assign capture  = ~arb_wait;

  // Next-state: slot capture, priority selection and transaction sequencing.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    ir_vld_d      = ir_vld_q;
    ir_addr_d     = ir_addr_q;
    dr_vld_d      = dr_vld_q;
    dr_addr_d     = dr_addr_q;
    w_vld_d       = w_vld_q;
    w_addr_d      = w_addr_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;
    inst_rvalid_d = 1'b0;
    inst_roaddr_d = inst_roaddr_q;
    inst_rdata_d  = inst_rdata_q;
    data_rvalid_d = 1'b0;
    data_roaddr_d = data_roaddr_q;
    data_rdata_d  = data_rdata_q;

    if (capture) begin
      if (bus.INST_RDEN) begin
        ir_vld_d  = 1'b1;
        ir_addr_d = bus.INST_RIADDR;
      end
      if (bus.DATA_RDEN) begin
        dr_vld_d  = 1'b1;
        dr_addr_d = bus.DATA_RIADDR;
      end
      if (bus.DATA_WREN) begin
        w_vld_d  = 1'b1;
        w_addr_d = bus.DATA_WADDR;
        w_data_d = bus.DATA_WDATA;
        w_strb_d = bus.DATA_WSTRB;
      end
    end

    case (state_q)
      // Selection sees slots being captured on this same edge, so a fresh
      // request is issued in the very next cycle.
      ST_IDLE: begin
        if (w_vld_d)       state_d = ST_ISSUE_W;
        else if (dr_vld_d) state_d = ST_ISSUE_DR;
        else if (ir_vld_d) state_d = ST_ISSUE_IR;
      end
      ST_ISSUE_W: begin
        if (!bus.MEM_WAIT) begin
          w_vld_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE_DR: if (!bus.MEM_WAIT) state_d = ST_WAIT_DR;
      ST_ISSUE_IR: if (!bus.MEM_WAIT) state_d = ST_WAIT_IR;
      ST_WAIT_DR: begin
        if (bus.MEM_RVALID) begin
          data_rvalid_d = 1'b1;
          data_rdata_d  = bus.MEM_RDATA;
          data_roaddr_d = dr_addr_q;
          dr_vld_d      = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      ST_WAIT_IR: begin
        if (bus.MEM_RVALID) begin
          inst_rvalid_d = 1'b1;
          inst_rdata_d  = bus.MEM_RDATA;
          inst_roaddr_d = ir_addr_q;
          ir_vld_d      = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and slot registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // value of the others, independent of statement order.
    if (RST) begin
      state_q       <= ST_IDLE;
      ir_vld_q      <= 1'b0;
      ir_addr_q     <= '0;
      dr_vld_q      <= 1'b0;
      dr_addr_q     <= '0;
      w_vld_q       <= 1'b0;
      w_addr_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      inst_rvalid_q <= 1'b0;
      inst_roaddr_q <= '0;
      inst_rdata_q  <= '0;
      data_rvalid_q <= 1'b0;
      data_roaddr_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      ir_vld_q      <= ir_vld_d;
      ir_addr_q     <= ir_addr_d;
      dr_vld_q      <= dr_vld_d;
      dr_addr_q     <= dr_addr_d;
      w_vld_q       <= w_vld_d;
      w_addr_q      <= w_addr_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      inst_rvalid_q <= inst_rvalid_d;
      inst_roaddr_q <= inst_roaddr_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rvalid_q <= data_rvalid_d;
      data_roaddr_q <= data_roaddr_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  // Memory port is decoded from state; fields are zero outside ISSUE states.
  assign bus.MEM_WREN  = (state_q == ST_ISSUE_W);
  assign bus.MEM_WADDR = (state_q == ST_ISSUE_W) ? w_addr_q : '0;
  assign bus.MEM_WDATA = (state_q == ST_ISSUE_W) ? w_data_q : '0;
  assign bus.MEM_WSTRB = (state_q == ST_ISSUE_W) ? w_strb_q : '0;
  assign bus.MEM_RDEN  = (state_q == ST_ISSUE_DR) || (state_q == ST_ISSUE_IR);
  assign bus.MEM_RADDR = (state_q == ST_ISSUE_DR) ? dr_addr_q :
                         (state_q == ST_ISSUE_IR) ? ir_addr_q : '0;

  assign bus.ARB_WAIT    = arb_wait;
  assign bus.INST_RVALID = inst_rvalid_q;
  assign bus.INST_ROADDR = inst_roaddr_q;
  assign bus.INST_RDATA  = inst_rdata_q;
  assign bus.DATA_RVALID = data_rvalid_q;
  assign bus.DATA_ROADDR = data_roaddr_q;
  assign bus.DATA_RDATA  = data_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Each cycle: inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge. "Cycle N" in the
// comments counts from the cycle in which the request is driven (cycle 0).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of a new cycle).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to mid-cycle for sampling.
  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    bus.INST_RDEN   = 1'b0;
    bus.INST_RIADDR = '0;
    bus.DATA_RDEN   = 1'b0;
    bus.DATA_RIADDR = '0;
    bus.DATA_WREN   = 1'b0;
    bus.DATA_WSTRB  = '0;
    bus.DATA_WADDR  = '0;
    bus.DATA_WDATA  = '0;
    bus.MEM_RVALID  = 1'b0;
    bus.MEM_RDATA   = '0;
    bus.MEM_WAIT    = 1'b1;

    // ---------------- Reset ----------------
    cyc(); cyc(); smp();
    check("rst_arb_wait_follows_mem_wait", bus.ARB_WAIT, 1);
    cyc(); rst = 1'b0; bus.MEM_WAIT = 1'b0; smp();
    check("rst_arb_wait", bus.ARB_WAIT, 0);
    check("rst_mem_rden", bus.MEM_RDEN, 0);
    check("rst_mem_raddr", bus.MEM_RADDR, 0);
    check("rst_mem_wren", bus.MEM_WREN, 0);
    check("rst_mem_waddr", bus.MEM_WADDR, 0);
    check("rst_mem_wdata", bus.MEM_WDATA, 0);
    check("rst_mem_wstrb", bus.MEM_WSTRB, 0);
    check("rst_inst_rvalid", bus.INST_RVALID, 0);
    check("rst_inst_roaddr", bus.INST_ROADDR, 0);
    check("rst_data_rdata", bus.DATA_RDATA, 0);
    // Stray memory response while idle must be ignored
    cyc(); bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = 32'h0000_0055; smp();
    cyc(); bus.MEM_RVALID = 1'b0; smp();
    check("stray_inst_rvalid", bus.INST_RVALID, 0);
    check("stray_data_rvalid", bus.DATA_RVALID, 0);
    check("stray_inst_rdata", bus.INST_RDATA, 0);
    check("stray_arb_wait", bus.ARB_WAIT, 0);

    // ---------------- Inst read 0x100, L=2 ----------------
    cyc(); bus.INST_RDEN = 1'b1; bus.INST_RIADDR = 32'h100; smp();   // cycle 0
    check("ir_c0_arb_wait", bus.ARB_WAIT, 0);
    cyc(); bus.INST_RDEN = 1'b0; smp();                              // cycle 1
    check("ir_c1_mem_rden", bus.MEM_RDEN, 1);
    check("ir_c1_mem_raddr", bus.MEM_RADDR, 32'h100);
    check("ir_c1_arb_wait", bus.ARB_WAIT, 1);
    cyc(); smp();                                                    // cycle 2
    check("ir_c2_mem_rden", bus.MEM_RDEN, 0);
    cyc(); bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = 32'hDEAD_BEEF; smp(); // cycle 3
    check("ir_c3_inst_rvalid", bus.INST_RVALID, 0);
    cyc(); bus.MEM_RVALID = 1'b0; smp();                             // cycle 4
    check("ir_c4_inst_rvalid", bus.INST_RVALID, 1);
    check("ir_c4_inst_roaddr", bus.INST_ROADDR, 32'h100);
    check("ir_c4_inst_rdata", bus.INST_RDATA, 32'hDEAD_BEEF);
    check("ir_c4_data_rvalid", bus.DATA_RVALID, 0);
    check("ir_c4_arb_wait", bus.ARB_WAIT, 0);
    cyc(); smp();                                                    // cycle 5
    check("ir_c5_inst_rvalid", bus.INST_RVALID, 0);
    check("ir_c5_inst_rdata_hold", bus.INST_RDATA, 32'hDEAD_BEEF);

    // ---------------- W + DR + IR same cycle, L=1 ----------------
    cyc();                                                           // cycle 0
    bus.DATA_WREN = 1'b1; bus.DATA_WADDR = 32'h20; bus.DATA_WDATA = 32'h1122_3344; bus.DATA_WSTRB = 4'hF;
    bus.DATA_RDEN = 1'b1; bus.DATA_RIADDR = 32'h40;
    bus.INST_RDEN = 1'b1; bus.INST_RIADDR = 32'h0;
    smp();
    cyc(); bus.DATA_WREN = 1'b0; bus.DATA_RDEN = 1'b0; bus.INST_RDEN = 1'b0; smp(); // cycle 1
    check("tri_c1_mem_wren", bus.MEM_WREN, 1);
    check("tri_c1_mem_waddr", bus.MEM_WADDR, 32'h20);
    check("tri_c1_mem_wdata", bus.MEM_WDATA, 32'h1122_3344);
    check("tri_c1_mem_wstrb", bus.MEM_WSTRB, 4'hF);
    check("tri_c1_mem_rden", bus.MEM_RDEN, 0);
    cyc(); smp();                                                    // cycle 2 (gap)
    check("tri_c2_mem_wren", bus.MEM_WREN, 0);
    check("tri_c2_mem_rden", bus.MEM_RDEN, 0);
    check("tri_c2_arb_wait", bus.ARB_WAIT, 1);
    cyc(); smp();                                                    // cycle 3
    check("tri_c3_mem_rden", bus.MEM_RDEN, 1);
    check("tri_c3_mem_raddr", bus.MEM_RADDR, 32'h40);
    cyc(); bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = 32'hCAFE_0001; smp(); // cycle 4
    check("tri_c4_mem_rden", bus.MEM_RDEN, 0);
    cyc(); bus.MEM_RVALID = 1'b0; smp();                             // cycle 5
    check("tri_c5_data_rvalid", bus.DATA_RVALID, 1);
    check("tri_c5_data_roaddr", bus.DATA_ROADDR, 32'h40);
    check("tri_c5_data_rdata", bus.DATA_RDATA, 32'hCAFE_0001);
    check("tri_c5_inst_rvalid", bus.INST_RVALID, 0);
    check("tri_c5_arb_wait", bus.ARB_WAIT, 1);
    cyc(); smp();                                                    // cycle 6
    check("tri_c6_mem_rden", bus.MEM_RDEN, 1);
    check("tri_c6_mem_raddr", bus.MEM_RADDR, 32'h0);
    check("tri_c6_data_rvalid", bus.DATA_RVALID, 0);
    cyc(); bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = 32'h0000_A5A5; smp(); // cycle 7
    cyc(); bus.MEM_RVALID = 1'b0; smp();                             // cycle 8
    check("tri_c8_inst_rvalid", bus.INST_RVALID, 1);
    check("tri_c8_inst_roaddr", bus.INST_ROADDR, 32'h0);
    check("tri_c8_inst_rdata", bus.INST_RDATA, 32'h0000_A5A5);
    check("tri_c8_data_rdata_hold", bus.DATA_RDATA, 32'hCAFE_0001);
    check("tri_c8_arb_wait", bus.ARB_WAIT, 0);

    // ---------------- MEM_WAIT stall in ISSUE_DR; requests while stalled ----------------
    cyc(); bus.DATA_RDEN = 1'b1; bus.DATA_RIADDR = 32'h80; smp();     // cycle 0
    cyc(); bus.DATA_RDEN = 1'b0; bus.MEM_WAIT = 1'b1; smp();         // cycle 1
    check("st_c1_mem_rden", bus.MEM_RDEN, 1);
    check("st_c1_mem_raddr", bus.MEM_RADDR, 32'h80);
    check("st_c1_arb_wait", bus.ARB_WAIT, 1);
    cyc(); bus.INST_RDEN = 1'b1; bus.INST_RIADDR = 32'h300;
    bus.DATA_WREN = 1'b1; bus.DATA_WADDR = 32'h44; smp();             // cycle 2
    check("st_c2_mem_rden", bus.MEM_RDEN, 1);
    check("st_c2_mem_raddr", bus.MEM_RADDR, 32'h80);
    check("st_c2_arb_wait", bus.ARB_WAIT, 1);
    cyc(); smp();                                                    // cycle 3
    check("st_c3_mem_rden", bus.MEM_RDEN, 1);
    check("st_c3_mem_raddr", bus.MEM_RADDR, 32'h80);
    check("st_c3_mem_wren", bus.MEM_WREN, 0);
    check("st_c3_arb_wait", bus.ARB_WAIT, 1);
    cyc(); bus.MEM_WAIT = 1'b0; smp();                               // cycle 4: accepted
    check("st_c4_mem_rden", bus.MEM_RDEN, 1);
    check("st_c4_mem_raddr", bus.MEM_RADDR, 32'h80);
    check("st_c4_arb_wait", bus.ARB_WAIT, 1);
    cyc(); bus.INST_RDEN = 1'b0; bus.DATA_WREN = 1'b0;
    bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = 32'h0000_0077; smp();      // cycle 5
    check("st_c5_mem_rden", bus.MEM_RDEN, 0);
    cyc(); bus.MEM_RVALID = 1'b0; smp();                             // cycle 6
    check("st_c6_data_rvalid", bus.DATA_RVALID, 1);
    check("st_c6_data_roaddr", bus.DATA_ROADDR, 32'h80);
    check("st_c6_data_rdata", bus.DATA_RDATA, 32'h0000_0077);
    check("st_c6_arb_wait", bus.ARB_WAIT, 0);
    for (int i = 7; i <= 9; i++) begin
      cyc(); smp();
      check($sformatf("st_c%0d_no_extra_rden", i), bus.MEM_RDEN, 0);
      check($sformatf("st_c%0d_no_extra_wren", i), bus.MEM_WREN, 0);
    end

    // ---------------- Reset during WAIT_IR, late MEM_RVALID ----------------
    cyc(); bus.INST_RDEN = 1'b1; bus.INST_RIADDR = 32'h200; smp();    // cycle 0
    cyc(); bus.INST_RDEN = 1'b0; smp();                              // cycle 1
    check("rr_c1_mem_rden", bus.MEM_RDEN, 1);
    cyc(); rst = 1'b1; smp();                                        // cycle 2 (WAIT_IR)
    check("rr_c2_mem_rden", bus.MEM_RDEN, 0);
    cyc(); rst = 1'b0; bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = 32'h0000_0BAD; smp(); // cycle 3
    check("rr_c3_arb_wait", bus.ARB_WAIT, 0);
    check("rr_c3_mem_rden", bus.MEM_RDEN, 0);
    cyc(); bus.MEM_RVALID = 1'b0; smp();                             // cycle 4
    check("rr_c4_inst_rvalid", bus.INST_RVALID, 0);
    check("rr_c4_inst_rdata", bus.INST_RDATA, 0);
    check("rr_c4_inst_roaddr", bus.INST_ROADDR, 0);
    check("rr_c4_mem_rden", bus.MEM_RDEN, 0);
    check("rr_c4_arb_wait", bus.ARB_WAIT, 0);
    // A fresh request is served normally after the reset
    cyc(); bus.INST_RDEN = 1'b1; bus.INST_RIADDR = 32'h204; smp();    // cycle 5
    cyc(); bus.INST_RDEN = 1'b0; smp();                              // cycle 6
    check("rr_c6_mem_rden", bus.MEM_RDEN, 1);
    check("rr_c6_mem_raddr", bus.MEM_RADDR, 32'h204);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
